layer_featuremap_streamer: RTL and testbench

//  Producer end of the per-layer feature-map stream. On start, reads one feature map (all channels packed
//  per pixel) from a synchronous memory in raster order. Drives data_out/valid_out into a layer's

---
 rtl/yolo_stream_pkg.sv | 21 ++
 rtl/raster_counter.sv | 46 ++++
 rtl/layer_featuremap_streamer.sv | 131 +++++++++++++
 tb/tb_layer_featuremap_streamer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_stream_pkg.sv
// Shared types and constants for the inter-layer feature-map stream (reader and write-side collector).
package yolo_stream_pkg;

  localparam int unsigned CH_WIDTH       = 32;
  localparam int unsigned CH_PER_WORD    = 32;
  localparam int unsigned DATA_WIDTH_DEF = CH_WIDTH * CH_PER_WORD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stream_state_t;

  // Linear raster index of a pixel in a width x width map.
  function automatic int unsigned raster_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column-first row/col raster counter wrapping at LIMIT-1; shared by the stream reader and collector.
module raster_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clr,
  output logic [CW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_first,
  output logic          o_last
);

  logic [CW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_col_wrap;
  logic          w_row_wrap;

  assign w_col_wrap = (r_col == CW'(LIMIT - 1));
  assign w_row_wrap = (r_row == CW'(LIMIT - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_first = (r_row == '0) && (r_col == '0);
  assign o_last  = w_row_wrap && w_col_wrap;

endmodule

// File: rtl/layer_featuremap_streamer.sv
// Streams one feature map from the inter-layer RAM to a conv bank, one pixel per cycle, raster order.
// Macro LAYER_STREAM_PAD_EN adds a 1-pixel zero border (W = IMG_SIZE+2) without reading memory for it.
module layer_featuremap_streamer
  import yolo_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_SIZE   = 104,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  last_out,
  output logic                  busy,
  output logic                  done
);

`ifdef LAYER_STREAM_PAD_EN
  localparam int unsigned W = IMG_SIZE + 2;
`else
  localparam int unsigned W = IMG_SIZE;
`endif
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  stream_state_t         r_state;
  stream_state_t         w_state_next;
  logic                  r_drain;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_v1;
  logic                  r_l1;
  logic                  r_p1;
  logic                  w_issue;
  logic                  w_launch;
  logic                  w_pad;
  logic                  w_rd;
  logic [CW-1:0]         w_row;
  logic [CW-1:0]         w_col;
  logic                  w_first;
  logic                  w_last;

  raster_counter #(
    .LIMIT(W),
    .CW   (CW)
  ) u_raster_counter (
    .i_clk  (Clk),
    .i_rst  (Rst),
    .i_en   (w_issue),
    .i_clr  (w_launch),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_first(w_first),
    .o_last (w_last)
  );

`ifdef LAYER_STREAM_PAD_EN
  assign w_pad = (w_row == '0) || (w_row == CW'(W - 1)) || (w_col == '0) || (w_col == CW'(W - 1));
  logic w_unused_first;
  assign w_unused_first = w_first;
`else
  assign w_pad = 1'b0;
  logic [2*CW:0] w_unused_rc;
  assign w_unused_rc = {w_first, w_row, w_col};
`endif

  assign w_rd      = w_issue & ~w_pad;
  assign mem_rd_en = w_rd;
  assign mem_addr  = r_addr;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Start is only honoured in IDLE, so mid-frame and DONE-cycle pulses are dropped.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_issue      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = ISSUE;
          w_launch     = 1'b1;
        end
      end
      ISSUE: begin
        w_issue = 1'b1;
        if (w_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Stage 1 tracks the memory read, stage 2 registers the pixel; data_out holds when idle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_drain   <= 1'b0;
      r_addr    <= '0;
      r_v1      <= 1'b0;
      r_l1      <= 1'b0;
      r_p1      <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_drain <= (r_state == DRAIN) && !r_drain;
      if (w_launch)  r_addr <= '0;
      else if (w_rd) r_addr <= r_addr + ADDR_WIDTH'(1);
      r_v1      <= w_issue;
      r_l1      <= w_issue & w_last;
      r_p1      <= w_issue & w_pad;
      valid_out <= r_v1;
      last_out  <= r_l1;
      if (r_v1) data_out <= r_p1 ? '0 : mem_rdata;
      busy <= (w_state_next == ISSUE) || (w_state_next == DRAIN);
      done <= (w_state_next == DONE);
    end
  end

endmodule

// File: tb/tb_layer_featuremap_streamer.sv
// Directed bench for layer_featuremap_streamer (IMG_SIZE=4); honours LAYER_STREAM_PAD_EN when defined.
module tb_layer_featuremap_streamer;
  import yolo_stream_pkg::*;

  localparam int IMG = 4;
  localparam int AW  = 4;
  localparam int DW  = 1024;
`ifdef LAYER_STREAM_PAD_EN
  localparam int W   = IMG + 2;
  localparam int RD3 = 0;
`else
  localparam int W   = IMG;
  localparam int RD3 = 7;
`endif
  localparam int N = W * W;
  localparam int R = IMG * IMG;

  logic          Clk;
  logic          Rst;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          last_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  layer_featuremap_streamer #(
    .DATA_WIDTH(DW),
    .IMG_SIZE  (IMG),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (start),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .data_out (data_out),
    .valid_out(valid_out),
    .last_out (last_out),
    .busy     (busy),
    .done     (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous memory: word i = {32{i}}, data one cycle after the read strobe.
  always @(posedge Clk) begin
    if (mem_rd_en) mem_rdata <= {32{32'(mem_addr)}};
  end

  typedef struct {
    int s0, s1, s2;
    int ron, roff;
    int ncyc;
    int f0, f1;
    int n_valid, n_last, n_done, n_rd;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [DW-1:0] word_of(input int i);
    logic [31:0] w;
    w = 32'(i);
    return {32{w}};
  endfunction

  function automatic bit slot_pad(input int s);
`ifdef LAYER_STREAM_PAD_EN
    int r, c;
    r = s / W;
    c = s % W;
    return (r == 0) || (r == W - 1) || (c == 0) || (c == W - 1);
`else
    return (s < 0);
`endif
  endfunction

  function automatic int slot_word(input int s);
`ifdef LAYER_STREAM_PAD_EN
    return int'(raster_addr(32'(s / W - 1), 32'(s % W - 1), 32'(IMG)));
`else
    return s;
`endif
  endfunction

  task automatic chk(input string nm, input int k, input int c, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s scen%0d cyc%0d act=%0h req=%0h", nm, k, c, act, req);
    end
  endtask

  task automatic chk_idle_outputs(input string nm, input int k, input int c);
    chk({nm, "_ctrl"}, k, c, 64'({mem_rd_en, valid_out, last_out, busy, done}), 64'd0);
    chk({nm, "_addr"}, k, c, 64'(mem_addr), 64'd0);
    chk({nm, "_data"}, k, c, 64'(data_out != '0), 64'd0);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic [DW-1:0] hold, e_data;
    logic e_busy, e_valid, e_last, e_done, e_rd, in_rst;
    int   e_addr, es, f;
    int   nv, nl, nd, nr;
    v = tbl[k];
    hold = '0;
    nv = 0; nl = 0; nd = 0; nr = 0;
    Rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    chk_idle_outputs("reset", k, -1);
    for (int c = 0; c < v.ncyc; c++) begin
      @(posedge Clk);
      #1;
      in_rst = (v.ron >= 0) && (c >= v.ron) && (c < v.roff);
      Rst   = in_rst;
      start = (c == v.s0) || (c == v.s1) || (c == v.s2);
      #1;
      e_busy = 0; e_valid = 0; e_last = 0; e_done = 0; e_rd = 0; e_addr = 0; es = 0;
      for (int j = 0; j < 2; j++) begin
        f = (j == 0) ? v.f0 : v.f1;
        if (f < 0) continue;
        if ((v.ron >= 0) && (f < v.ron) && (c >= v.ron)) continue;
        if (c >= f + 1 && c <= f + 2 + N) e_busy = 1;
        if (c >= f + 3 && c <= f + 2 + N) begin
          e_valid = 1;
          es = c - f - 3;
        end
        if (c == f + 2 + N) e_last = 1;
        if (c == f + 3 + N) e_done = 1;
        if (c >= f + 1 && c <= f + N && !slot_pad(c - f - 1)) begin
          e_rd   = 1;
          e_addr = slot_word(c - f - 1);
        end
      end
      if (e_valid)     e_data = slot_pad(es) ? '0 : word_of(slot_word(es));
      else if (in_rst) e_data = '0;
      else             e_data = hold;
      hold = e_data;
      chk("ctrl", k, c, 64'({mem_rd_en, valid_out, last_out, busy, done}),
          64'({e_rd, e_valid, e_last, e_busy, e_done}));
      total++;
      if (data_out !== e_data) begin
        bad++;
        $display("FAIL data scen%0d cyc%0d act=%0h req=%0h", k, c, data_out[63:0], e_data[63:0]);
      end
      if (e_rd || in_rst) chk("addr", k, c, 64'(mem_addr), 64'(e_addr));
      nv += int'(valid_out);
      nl += int'(last_out);
      nd += int'(done);
      nr += int'(mem_rd_en);
    end
    start = 1'b0;
    chk("n_valid", k, v.ncyc, 64'(nv), 64'(v.n_valid));
    chk("n_last",  k, v.ncyc, 64'(nl), 64'(v.n_last));
    chk("n_done",  k, v.ncyc, 64'(nd), 64'(v.n_done));
    chk("n_rd",    k, v.ncyc, 64'(nr), 64'(v.n_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nv;
    Rst   = 1'b1;
    start = 1'b0;

    //           s0  s1     s2  ron roff ncyc        f0  f1     nvalid  nlast nd nrd
    tbl[0] = '{0,  -1,    -1, -1, -1,  N + 8,      0,  -1,    N,      1,    1, R};
    tbl[1] = '{0,  5,     10, -1, -1,  N + 8,      0,  -1,    N,      1,    1, R};
    tbl[2] = '{0,  12,    -1, 8,  10,  12 + N + 8, 0,  12,    5 + N,  1,    1, RD3 + R};
    tbl[3] = '{0,  N + 4, -1, -1, -1,  2 * N + 12, 0,  N + 4, 2 * N,  2,    2, 2 * R};
    tbl[4] = '{0,  N + 3, -1, -1, -1,  2 * N + 12, 0,  -1,    N,      1,    1, R};
    tbl[5] = '{-1, -1,    -1, -1, -1,  100,        -1, -1,    0,      0,    0, 0};

    for (int k = 0; k < 6; k++) run_vec(k);

    // Start-to-first-pixel latency and frame completion with bounded waits.
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst   = 1'b0;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    #1;
    n = 1;
    while (!valid_out && n < 50) begin
      @(posedge Clk);
      #2;
      n++;
    end
    chk("latency", 6, n, 64'(n), 64'd3);
    nv = 0;
    while (!done && n < 200) begin
      nv += int'(valid_out);
      @(posedge Clk);
      #2;
      n++;
    end
    chk("done_seen", 6, n, 64'(done), 64'd1);
    chk("frame_len", 6, n, 64'(nv), 64'(N));
    chk("busy_at_done", 6, n, 64'(busy), 64'd0);
    chk("done_cycle", 6, n, 64'(n), 64'(N + 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
